tt_um_ternary_mvm_stream: RTL and testbench
===========================================

// Module: tt_um_ternary_mvm_stream
// PURPOSE
//  Parametrised streaming ternary matrix-vector multiplier, successor to the fixed 16x8 tile.
//  Accepts LANES input elements per beat over a valid/ready handshake and accumulates per-column sums in ACC_WIDTH.
//  After the last active row it drains one BIT_WIDTH result per column over a second valid/ready stream.
//  Row and column counts are set per job. Sits between the ui/uio input packer and the output serializer.
// PARAMETERS
//  IN_LEN     16  max input rows (matrix depth); must be a multiple of LANES
//  OUT_LEN    8   max output columns
//  BIT_WIDTH  8   signed width of input elements and output results
//  LANES      2   input elements accepted per beat
//  ACC_WIDTH  12  signed accumulator width per column; must be > BIT_WIDTH
// PORTS
//  clk        in   1                    clock, all state on rising edge
//  rst        in   1                    synchronous reset, active-high
//  start      in   1                    job start pulse; sampled only in IDLE
//  cfg_rows   in   $clog2(IN_LEN)+1     active rows for the job, latched at start
//  cfg_cols   in   $clog2(OUT_LEN)+1    active columns for the job, latched at start
//  W          in   2*IN_LEN*OUT_LEN     ternary weights; row r, col c at bits 2*(r*OUT_LEN+c)+:2
//  in_valid   in   1                    input beat valid
//  in_ready   out  1                    input beat accepted when in_valid&&in_ready
//  in_data    in   LANES*BIT_WIDTH      signed lanes; lane k (bits k*BIT_WIDTH+:BIT_WIDTH) = row base+k
//  out_valid  out  1                    result valid
//  out_ready  in   1                    result consumed when out_valid&&out_ready
//  out_data   out  BIT_WIDTH            signed result for current column
//  out_last   out  1                    high with out_valid on the final active column
//  busy       out  1                    state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; all accumulators, row/col pointers and latched cfg cleared.
//    Reset values: in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0.
//  - rst wins over every other input. Reset mid-job aborts it; nothing stale remains afterwards.
//  - Weight code: 2'b01 = +1, 2'b11 = -1, 2'b00 and 2'b10 = 0.
//    Operands are sign-extended to ACC_WIDTH before negation, so -(-128) = +128.
//  - Config clamp at start:
//    - rows: 0 or >IN_LEN -> IN_LEN; rounded down to a multiple of LANES; a result of 0 -> LANES.
//    - cols: 0 or >OUT_LEN -> OUT_LEN.
//  - IDLE: in_ready=0, out_valid=0. start=1 latches cfg, zeroes accumulators and row pointer, goes to ACCUM.
//  - ACCUM: in_ready=1.
//    - Each accepted beat: acc[c] += sum_k tern(W[row+k][c]) * lane k, for every active column c.
//      Inactive columns hold 0. Then row += LANES.
//    - Beats without in_valid leave all state unchanged.
//    - Acceptance of the beat with row+LANES == rows_lat -> DRAIN next cycle, col pointer = 0.
//  - DRAIN: out_valid=1, out_data = narrow(acc[col]), out_last = (col == cols_lat-1).
//    - Handshake: col++. On the last column -> IDLE next cycle.
//    - With out_ready=0, out_data and out_last hold stable.
//  - start outside IDLE is ignored. Accumulators wrap modulo 2^ACC_WIDTH.
//  - W must stay stable from start until the final output handshake; it is read combinationally each beat.
//  - Latency: out_valid rises the cycle after the final input beat is accepted.
//  - Throughput: 1 beat/cycle in ACCUM, 1 result/cycle in DRAIN. A job of R rows and C cols takes R/LANES + C cycles minimum.
// CONFIGURATION
//  - TERNARY_MVM_SATURATE_EN defined: narrow() clamps acc to [-2^(BIT_WIDTH-1), 2^(BIT_WIDTH-1)-1].
//  - Not defined: narrow() = acc[BIT_WIDTH-1:0] (two's-complement wrap). No saturation logic is synthesised.
// TESTING
//  Defaults are used unless stated.
//  1. All W=01, 8 beats of lanes {1,1}, cfg 16/8 -> 8 outputs of 16; out_last only on the 8th; busy falls 1 cycle later.
//  2. Col 0 all W=11, lanes {100,100}, cfg 16/1 -> acc=-1600.
//     Without TERNARY_MVM_SATURATE_EN out_data=8'hC0 (-64); with it out_data=8'h80 (-128).
//  3. cfg_rows=4, cfg_cols=3, rows 0..3 with W codes {01,11,10,00} per row, lanes {5,7},{-3,2} -> outputs match a model treating 10 as 0; exactly 3 outputs.
//  4. In DRAIN hold out_ready=0 for 5 cycles -> out_valid=1 and out_data frozen; no column skipped or repeated.
//  5. Random in_valid bubbles and a start pulse during ACCUM -> result identical to the gapless run; the second start is ignored.
//  6. rst=1 for 1 cycle mid-ACCUM -> next cycle busy=0, in_ready=0, out_valid=0; a fresh job then returns the exact expected sums.

Source files
------------

// File: rtl/tt_um_ternary_mvm_stream.sv
// Streaming ternary matrix-vector multiplier: LANES signed inputs per beat, per-column accumulation, then one result per column.
// Optional build macro TERNARY_MVM_SATURATE_EN makes narrow() clamp instead of wrapping.
module tt_um_ternary_mvm_stream #(
    parameter int IN_LEN    = 16,
    parameter int OUT_LEN   = 8,
    parameter int BIT_WIDTH = 8,
    parameter int LANES     = 2,
    parameter int ACC_WIDTH = 12
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [$clog2(IN_LEN):0]           cfg_rows,
    input  logic [$clog2(OUT_LEN):0]          cfg_cols,
    input  logic [2*IN_LEN*OUT_LEN-1:0]       W,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [LANES*BIT_WIDTH-1:0]        in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [BIT_WIDTH-1:0]              out_data,
    output logic                              out_last,
    output logic                              busy
);

    localparam int ROW_W  = $clog2(IN_LEN) + 1;
    localparam int COL_W  = $clog2(OUT_LEN) + 1;
    localparam int BEATS  = IN_LEN / LANES;
    localparam int BEAT_W = 2 * LANES * OUT_LEN;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    state_t                      state, state_next;
    logic [ROW_W-1:0]            row, rows_lat, rows_clamped;
    logic [COL_W-1:0]            col, cols_lat, cols_clamped;
    logic signed [ACC_WIDTH-1:0] acc      [OUT_LEN];
    logic signed [ACC_WIDTH-1:0] acc_next [OUT_LEN];
    logic signed [ACC_WIDTH-1:0] acc_sel;
    logic [BEAT_W-1:0]           beat_w;
    logic                        last_beat, last_col;

    // Operand is widened before negation so the most negative input negates exactly.
    function automatic logic signed [ACC_WIDTH-1:0] tern_mul(input logic [1:0] code,
                                                             input logic signed [BIT_WIDTH-1:0] x);
        logic signed [ACC_WIDTH-1:0] ext;
        ext = ACC_WIDTH'(x);
        case (code)
            2'b01:   tern_mul = ext;
            2'b11:   tern_mul = -ext;
            default: tern_mul = '0;
        endcase
    endfunction

`ifdef TERNARY_MVM_SATURATE_EN
    localparam logic signed [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'((2 ** (BIT_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_LO = ACC_WIDTH'(-(2 ** (BIT_WIDTH - 1)));

    function automatic logic [BIT_WIDTH-1:0] narrow(input logic signed [ACC_WIDTH-1:0] a);
        if (a > SAT_HI)
            narrow = BIT_WIDTH'(SAT_HI);
        else if (a < SAT_LO)
            narrow = BIT_WIDTH'(SAT_LO);
        else
            narrow = BIT_WIDTH'(a);
    endfunction
`else
    function automatic logic [BIT_WIDTH-1:0] narrow(input logic signed [ACC_WIDTH-1:0] a);
        narrow = BIT_WIDTH'(a);
    endfunction
`endif

    // Job configuration is normalised once at start so the datapath never sees odd row counts.
    always_comb begin
        rows_clamped = cfg_rows;
        if (cfg_rows == '0 || cfg_rows > ROW_W'(IN_LEN))
            rows_clamped = ROW_W'(IN_LEN);
        rows_clamped = rows_clamped - (rows_clamped % ROW_W'(LANES));
        if (rows_clamped == '0)
            rows_clamped = ROW_W'(LANES);
        cols_clamped = cfg_cols;
        if (cfg_cols == '0 || cfg_cols > COL_W'(OUT_LEN))
            cols_clamped = COL_W'(OUT_LEN);
    end

    assign last_beat = (row + ROW_W'(LANES)) == rows_lat;
    assign last_col  = col == (cols_lat - COL_W'(1));

    // Row pointer is always beat-aligned, so only BEATS weight slices can ever be selected.
    always_comb begin
        beat_w = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (row == ROW_W'(b * LANES))
                beat_w = W[b*BEAT_W +: BEAT_W];
        end
    end

    always_comb begin
        for (int c = 0; c < OUT_LEN; c++) begin
            logic signed [ACC_WIDTH-1:0] sum;
            sum = acc[c];
            if (COL_W'(c) < cols_lat) begin
                for (int k = 0; k < LANES; k++)
                    sum = sum + tern_mul(beat_w[2*(k*OUT_LEN+c) +: 2],
                                         in_data[k*BIT_WIDTH +: BIT_WIDTH]);
            end
            acc_next[c] = sum;
        end
    end

    always_comb begin
        acc_sel = '0;
        for (int c = 0; c < OUT_LEN; c++) begin
            if (col == COL_W'(c))
                acc_sel = acc[c];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ACCUM;
            ACCUM:   if (in_valid && last_beat) state_next = DRAIN;
            DRAIN:   if (out_ready && last_col) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row      <= '0;
            col      <= '0;
            rows_lat <= '0;
            cols_lat <= '0;
            for (int c = 0; c < OUT_LEN; c++)
                acc[c] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rows_lat <= rows_clamped;
                        cols_lat <= cols_clamped;
                        row      <= '0;
                        col      <= '0;
                        for (int c = 0; c < OUT_LEN; c++)
                            acc[c] <= '0;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        for (int c = 0; c < OUT_LEN; c++)
                            acc[c] <= acc_next[c];
                        row <= row + ROW_W'(LANES);
                        if (last_beat)
                            col <= '0;
                    end
                end
                DRAIN: begin
                    if (out_ready)
                        col <= col + COL_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = state == ACCUM;
    assign out_valid = state == DRAIN;
    assign busy      = state != IDLE;
    assign out_data  = (state == DRAIN) ? narrow(acc_sel) : '0;
    assign out_last  = (state == DRAIN) && last_col;

endmodule

// File: tb/tb_tt_um_ternary_mvm_stream.sv
// Randomised bench for tt_um_ternary_mvm_stream against an arithmetic matrix-vector model.
module tb_tt_um_ternary_mvm_stream;

    localparam int IN_LEN  = 16;
    localparam int OUT_LEN = 8;
    localparam int BW      = 8;
    localparam int LANES   = 2;

    logic                        clk = 1'b0;
    logic                        rst, start, in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic [4:0]                  cfg_rows;
    logic [3:0]                  cfg_cols;
    logic [2*IN_LEN*OUT_LEN-1:0] W;
    logic [LANES*BW-1:0]         in_data;
    logic [BW-1:0]               out_data;

    int       total = 0;
    int       bad = 0;
    int       x    [IN_LEN];
    logic [1:0] wt [IN_LEN][OUT_LEN];
    int       expv [OUT_LEN];
    int       got  [OUT_LEN];
    int       ref_got [OUT_LEN];

    always #5 clk = ~clk;

    tt_um_ternary_mvm_stream dut (
        .clk(clk), .rst(rst), .start(start), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
        .W(W), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy)
    );

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int tern(input logic [1:0] code);
        if (code == 2'b01) return 1;
        if (code == 2'b11) return -1;
        return 0;
    endfunction

    function automatic int narrow_model(input int a);
        int w;
        w = a & 4095;
        if (w >= 2048) w -= 4096;
`ifdef TERNARY_MVM_SATURATE_EN
        if (w > 127) return 127;
        if (w < -128) return -128;
        return w;
`else
        w = w & 255;
        if (w >= 128) w -= 256;
        return w;
`endif
    endfunction

    function automatic int eff_rows_of(input int cr);
        int r;
        r = cr;
        if (r == 0 || r > IN_LEN) r = IN_LEN;
        r = (r / LANES) * LANES;
        if (r == 0) r = LANES;
        return r;
    endfunction

    function automatic int eff_cols_of(input int cc);
        if (cc == 0 || cc > OUT_LEN) return OUT_LEN;
        return cc;
    endfunction

    task automatic randomize_data();
        for (int r = 0; r < IN_LEN; r++) begin
            x[r] = int'($urandom_range(255)) - 128;
            for (int c = 0; c < OUT_LEN; c++)
                wt[r][c] = 2'($urandom_range(3));
        end
    endtask

    task automatic run_job(input int cr, input int cc, input int bubble, input int stall,
                           input bit stray, input int stall_col);
        int er, ec, beats, b, col, budget, hold, acc;
        er = eff_rows_of(cr);
        ec = eff_cols_of(cc);
        beats = er / LANES;
        for (int r = 0; r < IN_LEN; r++)
            for (int c = 0; c < OUT_LEN; c++)
                W[2*(r*OUT_LEN+c) +: 2] = wt[r][c];
        for (int c = 0; c < OUT_LEN; c++) begin
            acc = 0;
            for (int r = 0; r < er; r++)
                acc += tern(wt[r][c]) * x[r];
            expv[c] = narrow_model(acc);
            got[c] = 0;
        end

        @(negedge clk);
        cfg_rows = 5'(cr);
        cfg_cols = 4'(cc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_on", int'(busy), 1);

        b = 0;
        budget = 0;
        while (b < beats && budget < 2000) begin
            for (int k = 0; k < LANES; k++)
                in_data[k*BW +: BW] = BW'(x[b*LANES+k]);
            in_valid = ($urandom_range(99) >= bubble);
            start = stray && (b == 1);
            if (start) begin
                cfg_rows = 5'd2;
                cfg_cols = 4'd1;
            end
            if (in_valid) check("in_ready", int'(in_ready), 1);
            @(negedge clk);
            if (in_valid) b++;
            budget++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        if (b < beats) check("in_timeout", b, beats);
        check("out_valid_latency", int'(out_valid), 1);

        col = 0;
        hold = 0;
        budget = 0;
        while (col < ec && budget < 2000) begin
            if (col == stall_col && hold < 5) begin
                out_ready = 1'b0;
                hold++;
            end else begin
                out_ready = ($urandom_range(99) >= stall);
            end
            check("out_valid", int'(out_valid), 1);
            check($sformatf("out_data_c%0d", col), int'($signed(out_data)), expv[col]);
            check($sformatf("out_last_c%0d", col), int'(out_last), int'(col == ec - 1));
            if (out_valid && out_ready) begin
                got[col] = int'($signed(out_data));
                col++;
            end
            @(negedge clk);
            budget++;
        end
        out_ready = 1'b0;
        if (col < ec) check("out_timeout", col, ec);
        check("busy_off", int'(busy), 0);
        check("out_valid_off", int'(out_valid), 0);
    endtask

    initial begin
        int codes [4];
        rst = 1'b1; start = 1'b0; cfg_rows = '0; cfg_cols = '0; W = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;

        // all +1 weights, unit inputs
        for (int r = 0; r < IN_LEN; r++) begin
            x[r] = 1;
            for (int c = 0; c < OUT_LEN; c++) wt[r][c] = 2'b01;
        end
        run_job(16, 8, 0, 0, 1'b0, -1);
        check("t1_sum", got[7], 16);

        // large negative sum exercising narrow()
        randomize_data();
        for (int r = 0; r < IN_LEN; r++) begin
            x[r] = 100;
            wt[r][0] = 2'b11;
        end
        run_job(16, 1, 0, 0, 1'b0, -1);
`ifdef TERNARY_MVM_SATURATE_EN
        check("t2_narrow", got[0], -128);
`else
        check("t2_narrow", got[0], -64);
`endif

        // short job with code 10 treated as zero
        randomize_data();
        codes[0] = 1; codes[1] = 3; codes[2] = 2; codes[3] = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < OUT_LEN; c++) wt[r][c] = 2'(codes[(r + c) % 4]);
        x[0] = 5; x[1] = 7; x[2] = -3; x[3] = 2;
        run_job(4, 3, 0, 0, 1'b0, -1);
        check("t3_col0", got[0], 5 - 7 + 0 + 0);

        // output back-pressure
        randomize_data();
        run_job(16, 8, 0, 0, 1'b0, 3);

        // bubbles plus ignored start versus gapless run
        randomize_data();
        run_job(12, 5, 0, 0, 1'b0, -1);
        for (int c = 0; c < OUT_LEN; c++) ref_got[c] = got[c];
        run_job(12, 5, 40, 0, 1'b1, -1);
        for (int c = 0; c < 5; c++) check($sformatf("t5_equiv_c%0d", c), got[c], ref_got[c]);

        // reset mid-accumulation
        randomize_data();
        @(negedge clk);
        cfg_rows = 5'd16; cfg_cols = 4'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_data = 16'h7f7f;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_busy", int'(busy), 0);
        check("t6_in_ready", int'(in_ready), 0);
        check("t6_out_valid", int'(out_valid), 0);
        check("t6_out_data", int'(out_data), 0);
        run_job(8, 6, 20, 20, 1'b0, -1);

        // configuration clamps
        randomize_data(); run_job(0, 0, 10, 10, 1'b0, -1);
        randomize_data(); run_job(7, 12, 10, 10, 1'b0, -1);
        randomize_data(); run_job(1, 3, 0, 0, 1'b0, -1);
        randomize_data(); run_job(20, 15, 10, 10, 1'b0, -1);

        // random jobs
        for (int j = 0; j < 6; j++) begin
            randomize_data();
            run_job(int'($urandom_range(31)), int'($urandom_range(15)), 30, 30, 1'b0, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
